// File: rtl/count_event_capture.sv
// count_event_capture
//
// Watches an upstream 8-bit free-running counter and turns two kinds of
// occurrences into timestamped events:
//   * match - the counter enters cmp_val while cmp_en is high
//   * wrap  - the counter rolls over from 8'hFF to 8'h00
// Events go into a small show-ahead FIFO that a downstream consumer drains
// with a valid/ready handshake. An event that arrives while the FIFO is full
// and nothing is being popped is dropped, and the sticky overflow flag is set.
//
// Build option:
//   WRAP_EVENT_EN  When defined, the block builds wrap detection and the 8-bit
//                  wrap counter. Wrap events set evt_type[1], and evt_stamp[15:8]
//                  carries the wrap count.
//                  When undefined, no wrap logic is built. evt_type[1] and
//                  evt_stamp[15:8] are then always zero.
//
// Ports:
//   clk        sole clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   count      sample of the upstream 8-bit counter, taken every cycle
//   cmp_val    compare value for match events
//   cmp_en     enables match detection
//   evt_valid  a head event is available
//   evt_ready  consumer accepts the head event (ignored while evt_valid=0)
//   evt_type   head event type: bit0 = match, bit1 = wrap
//   evt_stamp  head event timestamp {wrap_cnt, count}
//   overflow   sticky: at least one event was dropped since reset
//   level      FIFO occupancy, 0..DEPTH
//
// Parameters:
//   DEPTH      FIFO entries; power of two, 2..16
//   LVL_W      width of level; must equal clog2(DEPTH)+1

module count_event_capture #(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       count,
    input  logic [7:0]       cmp_val,
    input  logic             cmp_en,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_type,
    output logic [15:0]      evt_stamp,
    output logic             overflow,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    // Entry layout: {type[1:0], wrap_cnt[7:0], count[7:0]}
    localparam int ENT_W = 18;

    logic [7:0]       count_q;
    logic [7:0]       wrap_cnt_nxt;
    logic             match_det;
    logic             wrap_det;
    logic             evt_det;
    logic [ENT_W-1:0] new_entry;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             pop;
    logic             push;
    logic [ENT_W-1:0] head;

    // Previous counter sample. Reset to zero, so the first edge after reset
    // compares against 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count;
        end
    end

    // A match fires only on entry into cmp_val. A stalled counter therefore
    // yields a single event.
    assign match_det = cmp_en && (count == cmp_val) && (count != count_q);

`ifdef WRAP_EVENT_EN
    logic [7:0] wrap_cnt;

    assign wrap_det     = (count_q == 8'hFF) && (count == 8'h00);
    // The stamp uses the post-increment value, so a wrap event carries
    // its own wrap number.
    assign wrap_cnt_nxt = wrap_cnt + {7'd0, wrap_det};

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt <= 8'h00;
        end else begin
            wrap_cnt <= wrap_cnt_nxt;
        end
    end
`else
    assign wrap_det     = 1'b0;
    assign wrap_cnt_nxt = 8'h00;
`endif

    assign evt_det   = match_det || wrap_det;
    assign new_entry = {wrap_det, match_det, wrap_cnt_nxt, count};

    assign full = (level == LVL_W'(DEPTH));
    assign pop  = evt_valid && evt_ready;
    // When the FIFO is full, a simultaneous pop frees a slot on the same edge,
    // so the push is accepted.
    assign push = evt_det && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (evt_det && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Show-ahead output. Head fields are forced to zero while the FIFO is
    // empty, so stale RAM contents never reach the outputs (including after
    // a reset).
    assign evt_valid = (level != '0);
    assign head      = mem[rd_ptr];
    assign evt_type  = evt_valid ? head[17:16] : 2'b00;
    assign evt_stamp = evt_valid ? head[15:0]  : 16'h0000;

endmodule
